// File: rtl/keypad_scan_pkg.sv
// Shared calculator keypad constants, scan-state type and small helpers.
package keypad_scan_pkg;

  localparam int unsigned KEY_W = 5;

  localparam logic [KEY_W-1:0] KEY_0    = 5'h00;
  localparam logic [KEY_W-1:0] KEY_1    = 5'h01;
  localparam logic [KEY_W-1:0] KEY_2    = 5'h02;
  localparam logic [KEY_W-1:0] KEY_3    = 5'h03;
  localparam logic [KEY_W-1:0] KEY_4    = 5'h04;
  localparam logic [KEY_W-1:0] KEY_5    = 5'h05;
  localparam logic [KEY_W-1:0] KEY_6    = 5'h06;
  localparam logic [KEY_W-1:0] KEY_7    = 5'h07;
  localparam logic [KEY_W-1:0] KEY_8    = 5'h08;
  localparam logic [KEY_W-1:0] KEY_9    = 5'h09;
  localparam logic [KEY_W-1:0] KEY_A    = 5'h0A;
  localparam logic [KEY_W-1:0] KEY_B    = 5'h0B;
  localparam logic [KEY_W-1:0] KEY_C    = 5'h0C;
  localparam logic [KEY_W-1:0] KEY_D    = 5'h0D;
  localparam logic [KEY_W-1:0] KEY_E    = 5'h0E;
  localparam logic [KEY_W-1:0] KEY_F    = 5'h0F;
  localparam logic [KEY_W-1:0] KEY_NONE = 5'h10;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  // Active-low one-hot column drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Lowest-index low row; only meaningful when at least one row is low.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad scanner signal bundle; key_strobe exists only with KEYPAD_STROBE_EN.
interface keypad_scan_if;
  import keypad_scan_pkg::*;

  logic [3:0]       row_in;
  logic [3:0]       col_out;
  logic [KEY_W-1:0] key;
`ifdef KEYPAD_STROBE_EN
  logic             key_strobe;
`endif

`ifdef KEYPAD_STROBE_EN
  modport master (input row_in, output col_out, output key, output key_strobe);
  modport slave  (output row_in, input col_out, input key, input key_strobe);
`else
  modport master (input row_in, output col_out, output key);
  modport slave  (output row_in, input col_out, input key);
`endif
endinterface

// File: rtl/keypad_scan_tick_gen.sv
// Free-running divider producing a registered 1-cycle tick every CLK_DIV clocks.
module scan_tick_gen #(
  parameter int unsigned CLK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + CW'(1);
      tick    <= 1'b0;
    end
  end
endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with debounce; optional key_strobe under KEYPAD_STROBE_EN.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 1000,
  parameter int unsigned DEBOUNCE_TICKS = 16
) (
  input  logic          clk,
  input  logic          rst,
  keypad_scan_if.master kp
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             tick;
  logic [3:0]       sync1, sync2;
  scan_state_t      state;
  logic [1:0]       col_idx;
  logic [1:0]       row_cap;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       col_q;
  logic [KEY_W-1:0] key_q;
  logic             row_low;
`ifdef KEYPAD_STROBE_EN
  logic             strobe_q;
`endif

  scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Rows are asynchronous to clk; two flops before anything looks at them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 4'b1111;
      sync2 <= 4'b1111;
    end else begin
      sync1 <= kp.row_in;
      sync2 <= sync1;
    end
  end

  assign row_low = ~sync2[row_cap];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SCAN;
      col_idx  <= 2'd0;
      col_q    <= 4'b1110;
      row_cap  <= 2'd0;
      cnt      <= '0;
      key_q    <= KEY_NONE;
`ifdef KEYPAD_STROBE_EN
      strobe_q <= 1'b0;
`endif
    end else begin
`ifdef KEYPAD_STROBE_EN
      strobe_q <= 1'b0;
`endif
      if (tick) begin
        case (state)
          SCAN: begin
            if (&sync2) begin
              col_idx <= col_idx + 2'd1;
              col_q   <= col_drive(col_idx + 2'd1);
            end else begin
              row_cap <= low_row(sync2);
              cnt     <= '0;
              state   <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (row_low) begin
              if (cnt == CNT_LAST) begin
                key_q <= {1'b0, row_cap, col_idx};
                state <= HELD;
`ifdef KEYPAD_STROBE_EN
                strobe_q <= 1'b1;
`endif
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else begin
              state   <= SCAN;
              col_idx <= col_idx + 2'd1;
              col_q   <= col_drive(col_idx + 2'd1);
            end
          end
          HELD: begin
            // Only the captured row matters; other keys cannot change the code.
            if (!row_low) begin
              cnt   <= '0;
              state <= RELEASE;
            end
          end
          RELEASE: begin
            if (!row_low) begin
              if (cnt == CNT_LAST) begin
                key_q   <= KEY_NONE;
                state   <= SCAN;
                col_idx <= col_idx + 2'd1;
                col_q   <= col_drive(col_idx + 2'd1);
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else begin
              state <= HELD;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

  assign kp.col_out = col_q;
  assign kp.key     = key_q;
`ifdef KEYPAD_STROBE_EN
  assign kp.key_strobe = strobe_q;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (CLK_DIV=4, DEBOUNCE_TICKS=3) with a key-event scoreboard.
module tb_keypad_scan;
  import keypad_scan_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] press = '0;
  logic [3:0]  rows;
  int checks = 0;
  int errors = 0;
  int strobes = 0;
  bit mon_en = 1'b0;
  logic [4:0] prev_key = KEY_NONE;
  logic [4:0] sb[$];

  always #5 clk = ~clk;

  keypad_scan_if kp ();

  keypad_scan #(.CLK_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  // Passive matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r*4+c] && !kp.col_out[c]) rows[r] = 1'b0;
  end
  assign kp.row_in = rows;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next tick edge, bounded.
  task automatic tick_edge();
    int n = 0;
    @(negedge clk);
    while (dut.tick !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("tick_timeout", n, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_edge();
  endtask

  // Scoreboard: every change on key is popped and compared in order.
  always @(negedge clk) begin
    if (mon_en) begin
`ifdef KEYPAD_STROBE_EN
      if (kp.key_strobe === 1'b1) strobes++;
`endif
      if (kp.key !== prev_key) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_key", int'(kp.key), int'(prev_key));
        end else begin
          chk("sb_key", int'(kp.key), int'(sb.pop_front()));
        end
        prev_key = kp.key;
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col", int'(kp.col_out), 4'b1110);
    chk("rst_key", int'(kp.key), int'(KEY_NONE));
`ifdef KEYPAD_STROBE_EN
    chk("rst_strobe", int'(kp.key_strobe), 0);
`endif
    mon_en = 1'b1;
    rst = 1'b0;

    // Idle scan walks the columns with wrap.
    for (int i = 0; i < 8; i++) begin
      tick_edge();
      chk("idle_col", int'(kp.col_out), int'(col_drive(2'((i + 1) % 4))));
    end
    chk("idle_key", int'(kp.key), int'(KEY_NONE));

    // Key 6 (row 1, col 2): scan to col 2, detect, 3 debounce ticks.
    press[6] = 1'b1;
    sb.push_back(KEY_6);
    ticks(5);
    chk("k6_not_yet", int'(kp.key), int'(KEY_NONE));
    tick_edge();
    chk("k6_accept", int'(kp.key), int'(KEY_6));
    ticks(4);
    chk("k6_col_frozen", int'(kp.col_out), 4'b1011);
    chk("k6_held", int'(kp.key), int'(KEY_6));
    press[6] = 1'b0;
    sb.push_back(KEY_NONE);
    ticks(3);
    chk("k6_rel_pending", int'(kp.key), int'(KEY_6));
    tick_edge();
    chk("k6_released", int'(kp.key), int'(KEY_NONE));
    chk("k6_col_adv", int'(kp.col_out), 4'b0111);
    tick_edge();
    chk("k6_scan_resume", int'(kp.col_out), 4'b1110);

    // Bounce on key 0: low for the detect tick only.
    press[0] = 1'b1;
    tick_edge();
    chk("bounce_col_hold", int'(kp.col_out), 4'b1110);
    press[0] = 1'b0;
    tick_edge();
    chk("bounce_key", int'(kp.key), int'(KEY_NONE));
    chk("bounce_col1", int'(kp.col_out), 4'b1101);
    tick_edge();
    chk("bounce_col2", int'(kp.col_out), 4'b1011);

    // Key F with a 2-tick release bounce.
    press[15] = 1'b1;
    sb.push_back(KEY_F);
    ticks(5);
    chk("kf_accept", int'(kp.key), int'(KEY_F));
    press[15] = 1'b0;
    ticks(2);
    press[15] = 1'b1;
    ticks(3);
    chk("kf_rel_bounce", int'(kp.key), int'(KEY_F));
    press[15] = 1'b0;
    sb.push_back(KEY_NONE);
    ticks(4);
    chk("kf_released", int'(kp.key), int'(KEY_NONE));
    chk("kf_col_wrap", int'(kp.col_out), 4'b1110);

    // Key 5 held, second key on row 2 ignored, then reset mid-hold.
    press[5] = 1'b1;
    sb.push_back(KEY_5);
    ticks(5);
    chk("k5_accept", int'(kp.key), int'(KEY_5));
    press[9] = 1'b1;
    ticks(4);
    chk("k5_second_key", int'(kp.key), int'(KEY_5));
    chk("k5_col_frozen", int'(kp.col_out), 4'b1101);
    sb.push_back(KEY_NONE);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_key", int'(kp.key), int'(KEY_NONE));
    chk("rst_mid_col", int'(kp.col_out), 4'b1110);
    press = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick_edge();
    chk("post_rst_col1", int'(kp.col_out), 4'b1101);
    tick_edge();
    chk("post_rst_col2", int'(kp.col_out), 4'b1011);
    chk("post_rst_key", int'(kp.key), int'(KEY_NONE));

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
`ifdef KEYPAD_STROBE_EN
    chk("strobe_count", strobes, 3);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameters: CLK_DIV, default 1000, clk cycles per scan tick (>=2); DEBOUNCE_TICKS, default 16, consecutive stable ticks required to accept a press or a release (>=1).
REQ-002 Clock and reset: clk is the clock; rst is the reset, asynchronous and active-high.
REQ-003 Port clk, input, 1 bit: system clock.
REQ-004 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 Port row_in, input, 4 bits: keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 Port col_out, output, 4 bits: keypad column drive, active-low one-hot.
REQ-007 Port key, output, 5 bits: debounced key code 0x00-0x0F for keys 0-F, or KEY_NONE (0x10) when no key is accepted; consumed directly by the calculator control state machine.

Function
REQ-008 row_in SHALL pass through a 2-FF synchronizer before any use.
REQ-009 The scan tick SHALL be a 1-cycle pulse every CLK_DIV clk cycles, free-running from reset; all state-machine decisions SHALL occur only on tick cycles.
REQ-010 States SHALL be SCAN, DEBOUNCE, HELD and RELEASE.
REQ-011 SCAN, on a tick: if all synchronized rows are high, advance col_out one column (0->1->2->3->0 wrap); otherwise capture the lowest-index low row and the current column, clear the counter, go to DEBOUNCE, and hold col_out.
REQ-012 DEBOUNCE, on a tick: if the captured row is low, increment the counter; when it reaches DEBOUNCE_TICKS, set key = {row,col} as a 4-bit code (code = 4*row + col) and go to HELD. If the captured row is high, return to SCAN and advance the column; key stays KEY_NONE.
REQ-013 HELD, on a tick: if the captured row is high, clear the counter and go to RELEASE; otherwise stay in HELD. Other rows and columns are ignored; a second simultaneous key never changes key.
REQ-014 RELEASE, on a tick: if the captured row is high, increment the counter; on reaching DEBOUNCE_TICKS, set key = KEY_NONE, go to SCAN and advance the column. If the captured row is low, return to HELD with key unchanged.
REQ-015 key SHALL change only on the tick cycles named above; it is registered, glitch-free, and never takes a value other than 0x00-0x10.
REQ-016 Every accepted press SHALL be followed by at least one KEY_NONE period before the next code is presented, so the downstream state machine sees a press-release pair.

Reset
REQ-017 While rst is high: state = SCAN, col_out = 4'b1110, key = KEY_NONE, tick divider = 0, counter = 0, synchronizer flops = 4'b1111.
REQ-018 Reset asserted in any state, including mid-debounce or mid-hold, SHALL abandon the press; after release the block resumes at column 0 as if nothing were pressed.

Configuration
REQ-019 With macro KEYPAD_STROBE_EN defined, an extra output key_strobe (1 bit) SHALL pulse high for exactly one clk on the cycle key changes from KEY_NONE to a valid code; its reset value is 0. Without the macro, the port and its logic are absent and behaviour is otherwise identical.

Structure
REQ-020 KEY_0..KEY_F, KEY_NONE and the scan-state typedef SHALL live in the shared calculator package/defines, alongside the control state machine's key constants.
REQ-021 The tick divider SHALL be a sub-module named scan_tick_gen (parameter CLK_DIV; ports clk, rst, tick).

Verification (CLK_DIV=4, DEBOUNCE_TICKS=3)
REQ-022 Idle, no key pressed: col_out cycles 1110->1101->1011->0111->1110, one step per tick; key stays 0x10.
REQ-023 Row 1 held low while col 2 is driven, held 10 ticks: col_out freezes at 1011, key = 0x06 within 4 ticks of detection; row released: key = 0x10 after 3 further ticks, then scanning resumes.
REQ-024 Bounce: row 0 low for 1 tick, then high, on col 0: key stays 0x10 and scanning continues at col 1.
REQ-025 Release bounce: key 0x0F held, row 3 goes high for 2 ticks then low again: key stays 0x0F; a subsequent 3-tick release gives 0x10.
REQ-026 Key 0x05 held, then a second key on row 2 is pressed: key stays 0x05; rst pulsed mid-hold: key = 0x10 and col_out = 1110 immediately; with KEYPAD_STROBE_EN defined, key_strobe pulses exactly once per accepted press.
